// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding, word-address
// width and the default reset PC.
package if_fetch_stage_pkg;

   localparam int WAW = 30;
   localparam logic [WAW-1:0] RESET_PC_DEF = 30'h00000C00;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_e;

   // Word-address increment; wraps modulo 2^30 silently.
   function automatic logic [WAW-1:0] pc_inc(input logic [WAW-1:0] pc);
      return pc + 30'd1;
   endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request bus. Valid/ready rule: the fetch side raises
// imem_req with a stable imem_addr; the transfer completes in any cycle where
// imem_req && imem_ready, with imem_rdata valid in that same cycle.
interface if_fetch_stage_if;
   import if_fetch_stage_pkg::*;

   logic           imem_req;
   logic [WAW-1:0] imem_addr;
   logic           imem_ready;
   logic [31:0]    imem_rdata;

   modport master (output imem_req, output imem_addr,
                   input  imem_ready, input imem_rdata);
   modport slave  (input  imem_req, input imem_addr,
                   output imem_ready, output imem_rdata);
endinterface

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load wins over hold, flush wins over everything;
// with neither load nor hold the valid bit drops.
module if_fetch_stage_if_id_reg
   import if_fetch_stage_pkg::*;
(
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic           flush,
   input  logic           hold,
   input  logic [WAW-1:0] load_pcp1,
   input  logic [31:0]    load_instr,
   output logic           valid,
   output logic [WAW-1:0] pcp1,
   output logic [31:0]    instr
);

   always_ff @(posedge clk) begin
      if (reset) begin
         valid <= 1'b0;
         pcp1  <= '0;
         instr <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         pcp1  <= load_pcp1;
         instr <= load_instr;
      end else if (!hold) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC register, fetch FSM (REQ/WAIT/HOLD), watchdog and
// IF/ID register. Define IFETCH_CNT_EN to add the fetch_cnt output.
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [WAW-1:0] RESET_PC     = RESET_PC_DEF,
   parameter int             IMEM_LAT_MAX = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                id_stall,
   input  logic                id_redirect,
   input  logic [WAW-1:0]      id_jpc,
   if_fetch_stage_if.master    imem,
   output logic                ifid_valid,
   output logic [WAW-1:0]      ifid_pcp1,
   output logic [31:0]         ifid_instr,
   output logic                fetch_err,
`ifdef IFETCH_CNT_EN
   output logic [31:0]         fetch_cnt,
`endif
   output fetch_state_e        dbg_state
);

   fetch_state_e   state, state_n;
   logic [WAW-1:0] pc, pc_n, addr_q, addr_n, ld_pcp1;
   logic           kill, kill_n, load, flush;
   logic [31:0]    buf_q, buf_n, ld_instr, wcnt;

   assign dbg_state      = state;
   assign imem.imem_req  = !reset && (state != S_HOLD);
   // In WAIT the address comes from addr_q so a redirect cannot move it mid-request.
   assign imem.imem_addr = (state == S_REQ) ? pc : addr_q;

   always_comb begin
      state_n  = state;
      pc_n     = pc;
      addr_n   = addr_q;
      kill_n   = kill;
      buf_n    = buf_q;
      load     = 1'b0;
      flush    = 1'b0;
      ld_pcp1  = pc_inc(pc);
      ld_instr = imem.imem_rdata;
      case (state)
         S_REQ, S_WAIT: begin
            if (state == S_REQ) addr_n = pc;
            if (id_redirect) begin
               pc_n    = id_jpc;
               flush   = 1'b1;
               kill_n  = !imem.imem_ready;
               state_n = imem.imem_ready ? S_REQ : S_WAIT;
            end else if (imem.imem_ready) begin
               state_n = S_REQ;
               if (kill) begin
                  kill_n = 1'b0;
               end else if (!id_stall) begin
                  load = 1'b1;
                  pc_n = pc_inc(pc);
               end else begin
                  buf_n   = imem.imem_rdata;
                  state_n = S_HOLD;
               end
            end else begin
               state_n = S_WAIT;
            end
         end
         S_HOLD: begin
            if (id_redirect) begin
               pc_n    = id_jpc;
               flush   = 1'b1;
               state_n = S_REQ;
            end else if (!id_stall) begin
               load     = 1'b1;
               ld_instr = buf_q;
               pc_n     = pc_inc(pc);
               state_n  = S_REQ;
            end
         end
         default: state_n = S_REQ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_REQ;
         pc        <= RESET_PC;
         addr_q    <= RESET_PC;
         kill      <= 1'b0;
         buf_q     <= '0;
         wcnt      <= '0;
         fetch_err <= 1'b0;
      end else begin
         state  <= state_n;
         pc     <= pc_n;
         addr_q <= addr_n;
         kill   <= kill_n;
         buf_q  <= buf_n;
         // Counts consecutive unanswered WAIT cycles; fetch_err is sticky.
         if (state == S_WAIT && !imem.imem_ready) begin
            wcnt <= wcnt + 32'd1;
            if (IMEM_LAT_MAX != 0 && wcnt >= 32'(IMEM_LAT_MAX)) fetch_err <= 1'b1;
         end else begin
            wcnt <= '0;
         end
      end
   end

`ifdef IFETCH_CNT_EN
   always_ff @(posedge clk) begin
      if (reset)     fetch_cnt <= '0;
      else if (load) fetch_cnt <= fetch_cnt + 32'd1;
   end
`endif

   if_fetch_stage_if_id_reg u_ifid (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .flush      (flush),
      .hold       (id_stall),
      .load_pcp1  (ld_pcp1),
      .load_instr (ld_instr),
      .valid      (ifid_valid),
      .pcp1       (ifid_pcp1),
      .instr      (ifid_instr)
   );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a per-cycle vector table plus a watchdog
// sequence. Inputs change on the falling edge; outputs are checked 1ns later.
module tb_if_fetch_stage;
  import if_fetch_stage_pkg::*;

  logic clk = 1'b0;
  logic reset, id_stall, id_redirect;
  logic [29:0] id_jpc;
  logic ifid_valid, fetch_err;
  logic [29:0] ifid_pcp1;
  logic [31:0] ifid_instr;
  logic [31:0] cnt_obs;
  fetch_state_e dbg_state;
  int total = 0;
  int bad = 0;

  if_fetch_stage_if bus ();

  always #5 clk = ~clk;

  if_fetch_stage #(.IMEM_LAT_MAX(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_stall    (id_stall),
    .id_redirect (id_redirect),
    .id_jpc      (id_jpc),
    .imem        (bus.master),
    .ifid_valid  (ifid_valid),
    .ifid_pcp1   (ifid_pcp1),
    .ifid_instr  (ifid_instr),
    .fetch_err   (fetch_err),
`ifdef IFETCH_CNT_EN
    .fetch_cnt   (cnt_obs),
`endif
    .dbg_state   (dbg_state)
  );

`ifndef IFETCH_CNT_EN
  assign cnt_obs = '0;
`endif

  typedef struct {
    logic        rst, stall, red;
    logic [29:0] jpc;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [29:0] e_addr;
    logic [1:0]  e_st;
    logic        e_v;
    logic [29:0] e_pcp1;
    logic [31:0] e_instr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst, stall, red, input logic [29:0] jpc,
                     input logic rdy, input logic [31:0] rdata,
                     input logic e_req, input logic [29:0] e_addr,
                     input logic [1:0] e_st, input logic e_v,
                     input logic [29:0] e_pcp1, input logic [31:0] e_instr,
                     input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.stall = stall; v.red = red; v.jpc = jpc; v.rdy = rdy;
    v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_st = e_st;
    v.e_v = e_v; v.e_pcp1 = e_pcp1; v.e_instr = e_instr; v.e_cnt = e_cnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, stall, red, input logic [29:0] jpc,
                       input logic rdy, input logic [31:0] rdata);
    reset = rst; id_stall = stall; id_redirect = red; id_jpc = jpc;
    bus.imem_ready = rdy; bus.imem_rdata = rdata;
  endtask

  initial begin
    drive(1, 0, 0, '0, 0, '0);
    repeat (2) @(negedge clk);
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, {30'd0, S_REQ});
    chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_pcp1", {2'd0, ifid_pcp1}, 32'd0);
    chk("rst_instr", ifid_instr, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_cnt", cnt_obs, 32'd0);

    // rst stall red jpc rdy rdata | req addr state valid pcp1 instr cnt
    // zero-wait memory
    add(0,0,0,30'h0,1,32'h1111_0000, 1,30'hC00,0,0,30'h0,32'h0,0);
    add(0,0,0,30'h0,1,32'h1111_0001, 1,30'hC01,0,1,30'hC01,32'h1111_0000,1);
    add(0,0,0,30'h0,1,32'h1111_0002, 1,30'hC02,0,1,30'hC02,32'h1111_0001,2);
    // reset, then a 3-cycle-late response for 0xC00
    add(1,0,0,30'h0,0,32'h0,         0,30'hC03,0,1,30'hC03,32'h1111_0002,3);
    add(0,0,0,30'h0,0,32'h0,         1,30'hC00,0,0,30'h0,32'h0,0);
    add(0,0,0,30'h0,0,32'h0,         1,30'hC00,1,0,30'h0,32'h0,0);
    add(0,0,0,30'h0,0,32'h0,         1,30'hC00,1,0,30'h0,32'h0,0);
    add(0,0,0,30'h0,1,32'h2222_0000, 1,30'hC00,1,0,30'h0,32'h0,0);
    add(0,0,0,30'h0,0,32'h0,         1,30'hC01,0,1,30'hC01,32'h2222_0000,1);
    // response under id_stall: HOLD for 5 cycles, release loads the buffer
    add(0,1,0,30'h0,1,32'h2222_0001, 1,30'hC01,1,0,30'hC01,32'h2222_0000,1);
    for (int i = 0; i < 4; i++)
      add(0,1,0,30'h0,1,32'h0BAD_0000, 0,30'hC01,2,0,30'hC01,32'h2222_0000,1);
    add(0,0,0,30'h0,0,32'h0,         0,30'hC01,2,0,30'hC01,32'h2222_0000,1);
    add(0,0,0,30'h0,0,32'h0,         1,30'hC02,0,1,30'hC02,32'h2222_0001,2);
    // redirect during WAIT: address held, late response dropped
    add(0,0,1,30'h1060,0,32'h0,      1,30'hC02,1,0,30'hC02,32'h2222_0001,2);
    add(0,0,0,30'h0,0,32'h0,         1,30'hC02,1,0,30'hC02,32'h2222_0001,2);
    add(0,0,0,30'h0,1,32'hDEAD_BEEF, 1,30'hC02,1,0,30'hC02,32'h2222_0001,2);
    add(0,0,0,30'h0,0,32'h0,         1,30'h1060,0,0,30'hC02,32'h2222_0001,2);
    add(0,0,0,30'h0,1,32'h4444_0001, 1,30'h1060,1,0,30'hC02,32'h2222_0001,2);
    add(0,1,0,30'h0,0,32'h0,         1,30'h1061,0,1,30'h1061,32'h4444_0001,3);
    // redirect + stall + ready together: redirect wins
    add(0,1,1,30'h2000,1,32'h5555_0000, 1,30'h1061,1,1,30'h1061,32'h4444_0001,3);
    add(0,1,0,30'h0,0,32'h0,         1,30'h2000,0,0,30'h1061,32'h4444_0001,3);
    add(0,0,0,30'h0,1,32'h5555_0001, 1,30'h2000,1,0,30'h1061,32'h4444_0001,3);
    add(0,0,0,30'h0,0,32'h0,         1,30'h2001,0,1,30'h2001,32'h5555_0001,4);
    // redirect with same-cycle ready, then PC wrap at the top of the space
    add(0,0,1,30'h3FFFFFFF,1,32'h6666_0000, 1,30'h2001,1,0,30'h2001,32'h5555_0001,4);
    add(0,0,0,30'h0,1,32'h6666_0001, 1,30'h3FFFFFFF,0,0,30'h2001,32'h5555_0001,4);
    add(0,0,0,30'h0,0,32'h0,         1,30'h0,0,1,30'h0,32'h6666_0001,5);
    // redirect while in HOLD discards the buffered word
    add(0,1,0,30'h0,1,32'h7777_0000, 1,30'h0,1,0,30'h0,32'h6666_0001,5);
    add(0,1,1,30'h5,0,32'h0,         0,30'h0,2,0,30'h0,32'h6666_0001,5);
    add(0,0,0,30'h0,1,32'h7777_0001, 1,30'h5,0,0,30'h0,32'h6666_0001,5);
    add(0,0,0,30'h0,0,32'h0,         1,30'h6,0,1,30'h6,32'h7777_0001,6);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].stall, vq[i].red, vq[i].jpc, vq[i].rdy, vq[i].rdata);
      #1;
      chk($sformatf("v%0d_req", i), {31'd0, bus.imem_req}, {31'd0, vq[i].e_req});
      chk($sformatf("v%0d_addr", i), {2'd0, bus.imem_addr}, {2'd0, vq[i].e_addr});
      chk($sformatf("v%0d_state", i), {30'd0, dbg_state}, {30'd0, vq[i].e_st});
      chk($sformatf("v%0d_valid", i), {31'd0, ifid_valid}, {31'd0, vq[i].e_v});
      chk($sformatf("v%0d_pcp1", i), {2'd0, ifid_pcp1}, {2'd0, vq[i].e_pcp1});
      chk($sformatf("v%0d_instr", i), ifid_instr, vq[i].e_instr);
      chk($sformatf("v%0d_err", i), {31'd0, fetch_err}, 32'd0);
`ifdef IFETCH_CNT_EN
      chk($sformatf("v%0d_cnt", i), cnt_obs, vq[i].e_cnt);
`endif
      @(negedge clk);
    end

    // watchdog: memory never answers
    drive(1, 0, 0, '0, 0, '0);
    #1 chk("wd_rst_req", {31'd0, bus.imem_req}, 32'd0);
    @(negedge clk);
    drive(0, 0, 0, '0, 0, '0);
    #1 chk("wd_req_state", {30'd0, dbg_state}, {30'd0, S_REQ});
    @(negedge clk);
    for (int k = 1; k <= 5; k++) begin
      #1;
      chk($sformatf("wd_w%0d_state", k), {30'd0, dbg_state}, {30'd0, S_WAIT});
      chk($sformatf("wd_w%0d_err", k), {31'd0, fetch_err}, 32'd0);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("wd_err_hi%0d", k), {31'd0, fetch_err}, 32'd1);
      chk($sformatf("wd_addr%0d", k), {2'd0, bus.imem_addr}, 32'h0000_0C00);
      chk($sformatf("wd_req%0d", k), {31'd0, bus.imem_req}, 32'd1);
      @(negedge clk);
    end
`ifdef IFETCH_CNT_EN
    chk("wd_cnt", cnt_obs, 32'd0);
`endif
    drive(1, 0, 0, '0, 0, '0);
    @(negedge clk);
    #1 chk("wd_err_cleared", {31'd0, fetch_err}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
